// File: rtl/msi_dir_pkg.sv
// Shared definitions for the MSI home-node directory.
// Provides request/forward/reply message codes, directory state encoding
// and the controller FSM state enum.
package msi_dir_pkg;

  localparam int unsigned ProcW = 2;  // width of processor IDs on the wire

  // Request types (cache -> home)
  localparam logic [2:0] ReqReadMiss  = 3'b001;
  localparam logic [2:0] ReqWriteMiss = 3'b010;
  localparam logic [2:0] ReqUpgrade   = 3'b100;
  localparam logic [2:0] ReqWriteBack = 3'b101;

  // Forward types (home -> remote cache)
  localparam logic [2:0] FwdFetch    = 3'b011;
  localparam logic [2:0] FwdFetchInv = 3'b110;
  localparam logic [2:0] FwdInv      = 3'b111;

  // Reply types (home -> requester)
  localparam logic [1:0] RepDataValue  = 2'b01;
  localparam logic [1:0] RepUpgradeAck = 2'b10;

  typedef enum logic [1:0] {
    DirU = 2'b00,
    DirS = 2'b01,
    DirE = 2'b10
  } dirState_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StSendFwd,
    StWaitOwner,
    StReply
  } fsmState_e;

endpackage

// File: rtl/dir_store.sv
// Directory entries (state, sharer mask, owner) plus the backing memory.
// Ports: Clock/Reset_n; addr selects the line for both the combinational
// read port (rdState/rdSharers/rdOwner/rdData) and the synchronous write
// port (dirWrEn updates the entry, memWrEn updates the data word).
// Reset clears every entry to Uncached and every memory word to 0.
module dir_store
  import msi_dir_pkg::*;
#(
  parameter int unsigned NUM_PROC = 3,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [ADDR_W-1:0]   addr,
  output dirState_e           rdState,
  output logic [NUM_PROC-1:0] rdSharers,
  output logic [ProcW-1:0]    rdOwner,
  output logic [DATA_W-1:0]   rdData,
  input  logic                dirWrEn,
  input  dirState_e           wrState,
  input  logic [NUM_PROC-1:0] wrSharers,
  input  logic [ProcW-1:0]    wrOwner,
  input  logic                memWrEn,
  input  logic [DATA_W-1:0]   wrData
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  dirState_e           stateQ   [Depth];
  logic [NUM_PROC-1:0] sharersQ [Depth];
  logic [ProcW-1:0]    ownerQ   [Depth];
  logic [DATA_W-1:0]   memQ     [Depth];

  assign rdState   = stateQ[addr];
  assign rdSharers = sharersQ[addr];
  assign rdOwner   = ownerQ[addr];
  assign rdData    = memQ[addr];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        stateQ[i]   <= DirU;
        sharersQ[i] <= '0;
        ownerQ[i]   <= '0;
        memQ[i]     <= '0;
      end
    end else begin
      if (dirWrEn) begin
        stateQ[addr]   <= wrState;
        sharersQ[addr] <= wrSharers;
        ownerQ[addr]   <= wrOwner;
      end
      if (memWrEn) begin
        memQ[addr] <= wrData;
      end
    end
  end

endmodule

// File: rtl/msi_directory_home.sv
// MSI home-node directory controller.
// Request side: ReqValid/ReqReady handshake with ReqProc/ReqType/ReqAddress/ReqData.
// Forward side: FwdValid pulse with FwdType/FwdTarget/FwdAddress; the owner
// answers Fetch/FetchInvalidate with FwdAck + FwdData.
// Reply side: RepValid pulse with RepProc/RepType/RepData.
// Error pulses for one cycle on a protocol violation.
module msi_directory_home
  import msi_dir_pkg::*;
#(
  parameter int unsigned NUM_PROC = 3,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [ProcW-1:0]    ReqProc,
  input  logic [2:0]          ReqType,
  input  logic [ADDR_W-1:0]   ReqAddress,
  input  logic [DATA_W-1:0]   ReqData,
  output logic                FwdValid,
  output logic [2:0]          FwdType,
  output logic [NUM_PROC-1:0] FwdTarget,
  output logic [ADDR_W-1:0]   FwdAddress,
  input  logic                FwdAck,
  input  logic [DATA_W-1:0]   FwdData,
  output logic                RepValid,
  output logic [ProcW-1:0]    RepProc,
  output logic [1:0]          RepType,
  output logic [DATA_W-1:0]   RepData,
  output logic                Error
);

  fsmState_e           stateQ, stateD;
  logic [ProcW-1:0]    reqProcQ;
  logic [2:0]          reqTypeQ;
  logic [ADDR_W-1:0]   reqAddrQ;
  logic [DATA_W-1:0]   reqDataQ;
  // Outcome decided in LOOKUP, carried through the forward/reply states.
  logic [2:0]          fwdTypeQ, fwdTypeD;
  logic [NUM_PROC-1:0] fwdTargetQ, fwdTargetD;
  logic [1:0]          repTypeQ, repTypeD;
  logic [DATA_W-1:0]   repDataQ, repDataD;
  dirState_e           newStateQ, newStateD;
  logic [NUM_PROC-1:0] newSharersQ, newSharersD;
  logic [ProcW-1:0]    newOwnerQ, newOwnerD;
  logic                dirUpdQ, dirUpdD;

  dirState_e           curState, wrState;
  logic [NUM_PROC-1:0] curSharers, wrSharers;
  logic [ProcW-1:0]    curOwner, wrOwner;
  logic [DATA_W-1:0]   curData, wrData;
  logic                dirWrEn, memWrEn, error;

  dir_store #(
    .NUM_PROC (NUM_PROC),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_store (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .addr      (reqAddrQ),
    .rdState   (curState),
    .rdSharers (curSharers),
    .rdOwner   (curOwner),
    .rdData    (curData),
    .dirWrEn   (dirWrEn),
    .wrState   (wrState),
    .wrSharers (wrSharers),
    .wrOwner   (wrOwner),
    .memWrEn   (memWrEn),
    .wrData    (wrData)
  );

  logic [NUM_PROC-1:0] reqMask, ownerMask, otherSharers;
  logic                procBad, isOwner, inSharers;

  assign reqMask      = NUM_PROC'(1) << reqProcQ;
  assign ownerMask    = NUM_PROC'(1) << curOwner;
  assign otherSharers = curSharers & ~reqMask;
  assign procBad      = 32'(reqProcQ) >= NUM_PROC;
  assign isOwner      = curOwner == reqProcQ;
  assign inSharers    = |(curSharers & reqMask);

  always_comb begin
    stateD      = stateQ;
    fwdTypeD    = fwdTypeQ;
    fwdTargetD  = fwdTargetQ;
    repTypeD    = repTypeQ;
    repDataD    = repDataQ;
    newStateD   = newStateQ;
    newSharersD = newSharersQ;
    newOwnerD   = newOwnerQ;
    dirUpdD     = dirUpdQ;
    error       = 1'b0;
    dirWrEn     = 1'b0;
    memWrEn     = 1'b0;
    wrState     = newStateQ;
    wrSharers   = newSharersQ;
    wrOwner     = newOwnerQ;
    wrData      = FwdData;
    unique case (stateQ)
      StIdle: if (ReqValid) stateD = StLookup;
      StLookup: begin
        stateD      = StReply;
        fwdTypeD    = FwdInv;
        fwdTargetD  = '0;
        repTypeD    = RepDataValue;
        repDataD    = curData;
        newStateD   = curState;
        newSharersD = curSharers;
        newOwnerD   = curOwner;
        dirUpdD     = 1'b1;
        if (procBad) begin
          error  = 1'b1;
          stateD = StIdle;
        end else begin
          case (reqTypeQ)
            ReqReadMiss: begin
              if (curState == DirE && !isOwner) begin
                fwdTypeD    = FwdFetch;
                fwdTargetD  = ownerMask;
                newStateD   = DirS;
                newSharersD = ownerMask | reqMask;
                stateD      = StSendFwd;
              end else if (curState == DirE) begin
                // Owner missing on its own line: flag it, answer from memory.
                error   = 1'b1;
                dirUpdD = 1'b0;
              end else begin
                newStateD   = DirS;
                newSharersD = curSharers | reqMask;
              end
            end
            ReqWriteMiss, ReqUpgrade: begin
              // An upgrade that lost its race is served exactly like a write miss.
              newStateD   = DirE;
              newOwnerD   = reqProcQ;
              newSharersD = reqMask;
              if (curState == DirS) begin
                if (reqTypeQ == ReqUpgrade && inSharers) begin
                  repTypeD = RepUpgradeAck;
                  repDataD = '0;
                end
                if (|otherSharers) begin
                  fwdTypeD   = FwdInv;
                  fwdTargetD = otherSharers;
                  stateD     = StSendFwd;
                end
              end else if (curState == DirE) begin
                if (!isOwner) begin
                  fwdTypeD   = FwdFetchInv;
                  fwdTargetD = ownerMask;
                  stateD     = StSendFwd;
                end else begin
                  dirUpdD = 1'b0;
                end
              end
            end
            ReqWriteBack: begin
              stateD = StIdle;
              if (curState == DirE && isOwner) begin
                dirWrEn   = 1'b1;
                wrState   = DirU;
                wrSharers = '0;
                wrOwner   = '0;
                memWrEn   = 1'b1;
                wrData    = reqDataQ;
              end else begin
                error = 1'b1;
              end
            end
            default: begin
              error  = 1'b1;
              stateD = StIdle;
            end
          endcase
        end
      end
      StSendFwd: stateD = (fwdTypeQ == FwdInv) ? StReply : StWaitOwner;
      StWaitOwner: begin
        if (FwdAck) begin
          memWrEn  = 1'b1;
          wrData   = FwdData;
          repDataD = FwdData;
          stateD   = StReply;
        end
      end
      StReply: begin
        dirWrEn = dirUpdQ;
        stateD  = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ      <= StIdle;
      reqProcQ    <= '0;
      reqTypeQ    <= '0;
      reqAddrQ    <= '0;
      reqDataQ    <= '0;
      fwdTypeQ    <= '0;
      fwdTargetQ  <= '0;
      repTypeQ    <= '0;
      repDataQ    <= '0;
      newStateQ   <= DirU;
      newSharersQ <= '0;
      newOwnerQ   <= '0;
      dirUpdQ     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      fwdTypeQ    <= fwdTypeD;
      fwdTargetQ  <= fwdTargetD;
      repTypeQ    <= repTypeD;
      repDataQ    <= repDataD;
      newStateQ   <= newStateD;
      newSharersQ <= newSharersD;
      newOwnerQ   <= newOwnerD;
      dirUpdQ     <= dirUpdD;
      if (stateQ == StIdle && ReqValid) begin
        reqProcQ <= ReqProc;
        reqTypeQ <= ReqType;
        reqAddrQ <= ReqAddress;
        reqDataQ <= ReqData;
      end
    end
  end

  assign ReqReady   = stateQ == StIdle;
  assign FwdValid   = stateQ == StSendFwd;
  assign FwdType    = FwdValid ? fwdTypeQ : '0;
  assign FwdTarget  = FwdValid ? fwdTargetQ : '0;
  assign FwdAddress = FwdValid ? reqAddrQ : '0;
  assign RepValid   = stateQ == StReply;
  assign RepProc    = RepValid ? reqProcQ : '0;
  assign RepType    = RepValid ? repTypeQ : '0;
  assign RepData    = RepValid ? repDataQ : '0;
  assign Error      = error;

endmodule

// File: tb/tb_msi_directory_home.sv
module tb_msi_directory_home;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       ReqValid;
  logic       ReqReady;
  logic [1:0] ReqProc;
  logic [2:0] ReqType;
  logic [3:0] ReqAddress;
  logic [3:0] ReqData;
  logic       FwdValid;
  logic [2:0] FwdType;
  logic [2:0] FwdTarget;
  logic [3:0] FwdAddress;
  logic       FwdAck;
  logic [3:0] FwdData;
  logic       RepValid;
  logic [1:0] RepProc;
  logic [1:0] RepType;
  logic [3:0] RepData;
  logic       Error;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] RM = 3'b001, WM = 3'b010, UPG = 3'b100, WB = 3'b101;

  msi_directory_home #(
    .NUM_PROC (3),
    .ADDR_W   (4),
    .DATA_W   (4)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqProc    (ReqProc),
    .ReqType    (ReqType),
    .ReqAddress (ReqAddress),
    .ReqData    (ReqData),
    .FwdValid   (FwdValid),
    .FwdType    (FwdType),
    .FwdTarget  (FwdTarget),
    .FwdAddress (FwdAddress),
    .FwdAck     (FwdAck),
    .FwdData    (FwdData),
    .RepValid   (RepValid),
    .RepProc    (RepProc),
    .RepType    (RepType),
    .RepData    (RepData),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // Handshake on the next rising edge; returns at the negedge of the LOOKUP cycle.
  task automatic issue(input logic [1:0] p, input logic [2:0] t, input logic [3:0] a,
                       input logic [3:0] d);
    chk("req_ready", ReqReady, 1);
    ReqValid = 1'b1; ReqProc = p; ReqType = t; ReqAddress = a; ReqData = d;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0; ReqProc = '0; ReqType = '0; ReqAddress = '0; ReqData = '0;
    @(negedge Clock);
  endtask

  task automatic expectRep(input string tag, input logic [1:0] p, input logic [1:0] t,
                           input logic [3:0] d);
    chk({tag, "_rep_valid"}, RepValid, 1);
    chk({tag, "_rep_proc"}, RepProc, p);
    chk({tag, "_rep_type"}, RepType, t);
    chk({tag, "_rep_data"}, RepData, d);
    chk({tag, "_no_fwd"}, FwdValid, 0);
  endtask

  task automatic expectFwd(input string tag, input logic [2:0] t, input logic [2:0] tgt,
                           input logic [3:0] a);
    chk({tag, "_fwd_valid"}, FwdValid, 1);
    chk({tag, "_fwd_type"}, FwdType, t);
    chk({tag, "_fwd_target"}, FwdTarget, tgt);
    chk({tag, "_fwd_addr"}, FwdAddress, a);
    chk({tag, "_no_rep"}, RepValid, 0);
  endtask

  // Owner answers while the home sits in WAIT_OWNER; returns at the REPLY negedge.
  task automatic ackOwner(input logic [3:0] d);
    FwdAck = 1'b1; FwdData = d;
    @(posedge Clock);
    #1;
    FwdAck = 1'b0; FwdData = '0;
    @(negedge Clock);
  endtask

  initial begin
    Reset_n = 1'b0; ReqValid = 1'b0; ReqProc = '0; ReqType = '0; ReqAddress = '0;
    ReqData = '0; FwdAck = 1'b0; FwdData = '0;
    repeat (2) step();
    chk("rst_ready", ReqReady, 1);
    chk("rst_rep_valid", RepValid, 0);
    chk("rst_fwd_valid", FwdValid, 0);
    chk("rst_error", Error, 0);
    chk("rst_rep_data", RepData, 0);
    Reset_n = 1'b1;
    step();

    // P0 read miss on uncached 0x7: reply two cycles after handshake
    issue(0, RM, 4'h7, 0);
    chk("t1_lookup_no_rep", RepValid, 0);
    chk("t1_no_error", Error, 0);
    step(); expectRep("t1", 0, 2'b01, 0);
    step(); chk("t1_idle", ReqReady, 1);

    // P1 write miss, sharers=001 -> invalidate P0 then data reply
    issue(1, WM, 4'h7, 0);
    step(); expectFwd("t2", 3'b111, 3'b001, 4'h7);
    step(); expectRep("t2", 1, 2'b01, 0);
    step();

    // P1 writes back 6, then P2 reads it from memory
    issue(1, WB, 4'h7, 4'h6);
    chk("t3_wb_no_error", Error, 0);
    step();
    chk("t3_wb_no_rep", RepValid, 0);
    chk("t3_wb_idle", ReqReady, 1);
    issue(2, RM, 4'h7, 0);
    step(); expectRep("t3", 2, 2'b01, 4'h6);
    step();

    // P0 takes 0x4 exclusive, P2 read forces a Fetch with a 5-cycle stall
    issue(0, WM, 4'h4, 0);
    step(); expectRep("t4a", 0, 2'b01, 0);
    step();
    issue(2, RM, 4'h4, 0);
    step(); expectFwd("t4", 3'b011, 3'b001, 4'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_no_rep", RepValid, 0);
    end
    ackOwner(4'h3);
    expectRep("t4b", 2, 2'b01, 4'h3);
    step();

    // P0 upgrade with sharers=101: invalidate P2, UpgradeAck
    issue(0, UPG, 4'h4, 0);
    step(); expectFwd("t5", 3'b111, 3'b100, 4'h4);
    step(); expectRep("t5", 0, 2'b10, 0);
    step();
    // P2 upgrade now loses the race -> FetchInvalidate to P0
    issue(2, UPG, 4'h4, 0);
    step(); expectFwd("t5b", 3'b110, 3'b001, 4'h4);
    step(); chk("t5b_wait_no_rep", RepValid, 0);
    ackOwner(4'h9);
    expectRep("t5b", 2, 2'b01, 4'h9);
    step();

    // Line 0xA: empty invalidate mask, owner self-read error, fetched data in memory
    issue(0, RM, 4'hA, 0);
    step(); expectRep("t6a", 0, 2'b01, 0);
    step();
    issue(0, WM, 4'hA, 0);
    step(); expectRep("t6b_skip_fwd", 0, 2'b01, 0);
    step();
    issue(0, RM, 4'hA, 0);
    chk("t6c_error", Error, 1);
    step(); expectRep("t6c", 0, 2'b01, 0);
    chk("t6c_error_pulse", Error, 0);
    step();
    issue(1, RM, 4'hA, 0);
    step(); expectFwd("t6d", 3'b011, 3'b001, 4'hA);
    step();
    ackOwner(4'h5);
    expectRep("t6d", 1, 2'b01, 4'h5);
    step();
    issue(2, RM, 4'hA, 0);
    step(); expectRep("t6e_mem", 2, 2'b01, 4'h5);
    step();

    // Reset while waiting on the owner abandons the transaction
    issue(1, RM, 4'h4, 0);
    step(); expectFwd("t7", 3'b011, 3'b100, 4'h4);
    step();
    Reset_n = 1'b0;
    #1;
    chk("t7_rst_ready", ReqReady, 1);
    chk("t7_rst_no_rep", RepValid, 0);
    step();
    chk("t7_rst_hold_no_rep", RepValid, 0);
    Reset_n = 1'b1;
    step();
    issue(1, WM, 4'h4, 0);
    chk("t7_lookup_no_fwd", FwdValid, 0);
    step(); expectRep("t7_uncached", 1, 2'b01, 0);
    step();

    // Protocol errors: writeback to uncached line, bad type, bad processor
    issue(1, WB, 4'h2, 4'h5);
    chk("t8_wb_error", Error, 1);
    step();
    chk("t8_wb_error_pulse", Error, 0);
    chk("t8_wb_no_rep", RepValid, 0);
    issue(1, 3'b011, 4'h2, 0);
    chk("t8_type_error", Error, 1);
    step();
    chk("t8_type_no_rep", RepValid, 0);
    issue(3, RM, 4'h2, 0);
    chk("t8_proc_error", Error, 1);
    step();
    chk("t8_proc_no_rep", RepValid, 0);
    issue(0, WM, 4'h2, 0);
    step(); expectRep("t8_unchanged", 0, 2'b01, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msi_directory_home.md
Name: msi_directory_home

Overview:
- Home-node directory controller: the responder end of the MSI directory protocol whose initiator is each processor's L1 cache controller.
- Receives ReadMiss, WriteMiss, Invalidate (upgrade) and DataWriteBack requests from up to NUM_PROC caches.
- Keeps per-line directory state (Uncached/Shared/Exclusive), a sharer vector and the owner.
- Holds the backing memory array and issues Fetch, FetchInvalidate and Invalidate messages to remote caches.

Parameters:
NUM_PROC, 3, number of attached caches (processor IDs 0..NUM_PROC-1)
ADDR_W, 4, address width; directory/memory depth = 2**ADDR_W
DATA_W, 4, data word width

Ports:
Clock  input  1  single clock, rising-edge
Reset_n  input  1  asynchronous, active-low reset
ReqValid  input  1  request present
ReqReady  output  1  high only in IDLE; transfer when ReqValid&ReqReady
ReqProc  input  2  requesting processor ID
ReqType  input  3  001 ReadMiss, 010 WriteMiss, 100 Invalidate(upgrade), 101 DataWriteBack
ReqAddress  input  ADDR_W  line address
ReqData  input  DATA_W  writeback data (DataWriteBack only)
FwdValid  output  1  one-cycle pulse: forward message to FwdTarget
FwdType  output  3  011 Fetch, 110 FetchInvalidate, 111 Invalidate
FwdTarget  output  NUM_PROC  one-hot (Fetch*) or sharer mask (Invalidate)
FwdAddress  output  ADDR_W  line being forwarded
FwdAck  input  1  owner response to Fetch/FetchInvalidate
FwdData  input  DATA_W  owner's dirty data, valid with FwdAck
RepValid  output  1  one-cycle reply pulse to RepProc
RepProc  output  2  destination processor
RepType  output  2  01 DataValueReply, 10 UpgradeAck
RepData  output  DATA_W  line data (0 for UpgradeAck)
Error  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async, Reset_n=0): FSM→IDLE; every directory entry U, sharers 0, owner 0; memory words 0; all outputs 0 except ReqReady=1. Reset mid-transaction abandons it; no reply is issued.
- FSM: IDLE→LOOKUP on handshake; inputs latched at that edge.
- LOOKUP: decode request against the directory entry. Next state is SEND_FWD (forward needed), REPLY, or IDLE (writeback / error).
- SEND_FWD: FwdValid=1 for one cycle. Invalidate-type forwards go to REPLY (no ack). Fetch-type forwards go to WAIT_OWNER.
- WAIT_OWNER: hold until FwdAck (unbounded); then write FwdData into memory and go to REPLY.
- REPLY: RepValid=1 for one cycle; directory updated on the same edge; return to IDLE.
- Latency: uncontended read = 2 cycles from handshake to RepValid. Owner-involved read = 3 cycles + ack wait.
- ReadMiss:
  - U or S → reply memory data; sharers |= req; state S.
  - E, owner≠req → Fetch to owner; after ack, memory←FwdData; state S; sharers = owner|req; reply FwdData.
  - E, owner==req → Error pulse; reply memory data; entry unchanged.
- WriteMiss:
  - U → reply memory; state E; owner=req; sharers=req.
  - S → Invalidate to sharers&~req (SEND_FWD skipped if mask empty); reply memory; state E; owner=req.
  - E, owner≠req → FetchInvalidate; memory←FwdData; reply FwdData; owner=req.
- Invalidate (upgrade):
  - State S with req in sharers → Invalidate others (skipped if none); RepType=10, RepData=0; state E; owner=req.
  - Any other state (upgrade race lost) → processed exactly as WriteMiss.
- DataWriteBack:
  - State E and owner==req → memory←ReqData; state U; sharers 0; no reply.
  - Otherwise → Error pulse, no state change, no reply.
- Undefined ReqType or ReqProc≥NUM_PROC → Error, return to IDLE.
- Sharer mask width is exactly NUM_PROC. Owner is always a member of sharers while in state E.

Decomposition:
- Package msi_dir_pkg: request/forward/reply type codes, directory state encoding (U=2'b00, S=2'b01, E=2'b10), FSM state enum.
- Sub-module dir_store: directory entries plus memory array. One combinational read port, one synchronous write port, async clear.

Test Plan:
- After reset, P0 ReadMiss 0x7 → RepValid at handshake+2, RepData=0; dir[7]=S, sharers=001.
- P1 WriteMiss 0x7 (sharers=001) → Fwd Invalidate, target 001; then reply data 0; dir[7]=E, owner=1.
- P1 DataWriteBack 0x7 data 0x6 → no reply; P2 ReadMiss 0x7 → RepData=0x6, dir[7]=S.
- P0 WriteMiss 0x4, then P2 ReadMiss 0x4 → Fetch to target 001; stall 5 cycles; FwdAck with FwdData=0x3 → RepData=0x3; mem[4]=3; sharers=101.
- P0 upgrade 0x4 while sharers=101 → Invalidate to 100; then UpgradeAck; owner=0. P2 upgrade 0x4 now → handled as WriteMiss: FetchInvalidate to P0.
- Reset_n low during WAIT_OWNER → no RepValid; dir[4]=U; ReqReady=1 immediately. P1 writeback to an uncached line → Error pulse.
